// File: rtl/ibex_fetch_align_expand.sv
// Fetch realigner + RV32C expander between the fetch FIFO and ID.
// Ports: clk_i/rst_ni, flush_i/flush_pc_i, in_* word stream, out_* instr stream.

module ibex_compressed_decoder (
    input  logic [15:0] instr_i,
    output logic [31:0] instr_o,
    output logic        illegal_instr_o
);
    logic [15:0] c;
    assign c = instr_i;

    always_comb begin
        instr_o         = {16'h0, c};
        illegal_instr_o = 1'b0;
        unique case (c[1:0])
            2'b00: begin
                unique case (c[15:13])
                    3'b000: begin
                        instr_o = {2'b0, c[10:7], c[12:11], c[5], c[6],
                                   2'b00, 5'h02, 3'b000, 2'b01, c[4:2], 7'h13};
                        illegal_instr_o = (c[12:5] == 8'h0);
                    end
                    3'b010: instr_o = {5'b0, c[5], c[12:10], c[6], 2'b00,
                                       2'b01, c[9:7], 3'b010, 2'b01, c[4:2], 7'h03};
                    3'b110: instr_o = {5'b0, c[5], c[12], 2'b01, c[4:2],
                                       2'b01, c[9:7], 3'b010, c[11:10], c[6],
                                       2'b00, 7'h23};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            2'b01: begin
                unique case (c[15:13])
                    3'b000: instr_o = {{6{c[12]}}, c[12], c[6:2], c[11:7],
                                       3'b0, c[11:7], 7'h13};
                    3'b001, 3'b101: instr_o = {c[12], c[8], c[10:9], c[6], c[7],
                                               c[2], c[11], c[5:3], {9{c[12]}},
                                               4'b0, ~c[15], 7'h6f};
                    3'b010: instr_o = {{6{c[12]}}, c[12], c[6:2], 5'b0, 3'b0,
                                       c[11:7], 7'h13};
                    3'b011: begin
                        if (c[11:7] == 5'h02) begin
                            instr_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0,
                                       5'h02, 3'b000, 5'h02, 7'h13};
                        end else begin
                            instr_o = {{15{c[12]}}, c[6:2], c[11:7], 7'h37};
                        end
                        illegal_instr_o = ({c[12], c[6:2]} == 6'h0);
                    end
                    3'b100: begin
                        unique case (c[11:10])
                            2'b00, 2'b01: begin
                                instr_o = {1'b0, c[10], 5'b0, c[6:2], 2'b01, c[9:7],
                                           3'b101, 2'b01, c[9:7], 7'h13};
                                illegal_instr_o = c[12];
                            end
                            2'b10: instr_o = {{6{c[12]}}, c[12], c[6:2], 2'b01,
                                              c[9:7], 3'b111, 2'b01, c[9:7], 7'h13};
                            default: begin
                                unique case (c[6:5])
                                    2'b00: instr_o = {2'b01, 5'b0, 2'b01, c[4:2],
                                                      2'b01, c[9:7], 3'b000,
                                                      2'b01, c[9:7], 7'h33};
                                    2'b01: instr_o = {7'b0, 2'b01, c[4:2], 2'b01,
                                                      c[9:7], 3'b100, 2'b01,
                                                      c[9:7], 7'h33};
                                    2'b10: instr_o = {7'b0, 2'b01, c[4:2], 2'b01,
                                                      c[9:7], 3'b110, 2'b01,
                                                      c[9:7], 7'h33};
                                    default: instr_o = {7'b0, 2'b01, c[4:2], 2'b01,
                                                        c[9:7], 3'b111, 2'b01,
                                                        c[9:7], 7'h33};
                                endcase
                                illegal_instr_o = c[12];
                            end
                        endcase
                    end
                    default: instr_o = {{4{c[12]}}, c[6:5], c[2], 5'b0, 2'b01,
                                        c[9:7], 2'b00, c[13], c[11:10], c[4:3],
                                        c[12], 7'h63};
                endcase
            end
            2'b10: begin
                unique case (c[15:13])
                    3'b000: begin
                        instr_o = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], 7'h13};
                        illegal_instr_o = c[12];
                    end
                    3'b010: begin
                        instr_o = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'h02,
                                   3'b010, c[11:7], 7'h03};
                        illegal_instr_o = (c[11:7] == 5'h0);
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (c[6:2] != 5'h0) begin
                                instr_o = {7'b0, c[6:2], 5'b0, 3'b0, c[11:7], 7'h33};
                            end else begin
                                instr_o = {12'b0, c[11:7], 3'b0, 5'b0, 7'h67};
                                illegal_instr_o = (c[11:7] == 5'h0);
                            end
                        end else begin
                            if (c[6:2] != 5'h0) begin
                                instr_o = {7'b0, c[6:2], c[11:7], 3'b0, c[11:7], 7'h33};
                            end else if (c[11:7] == 5'h0) begin
                                instr_o = 32'h0010_0073;
                            end else begin
                                instr_o = {12'b0, c[11:7], 3'b000, 5'b00001, 7'h67};
                            end
                        end
                    end
                    3'b110: instr_o = {4'b0, c[8:7], c[12], c[6:2], 5'h02, 3'b010,
                                       c[11:9], 2'b00, 7'h23};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            default: ;
        endcase
    end
endmodule

module ibex_fetch_align_expand #(
    parameter bit          RVC      = 1'b1,
    parameter int unsigned HwDepth  = 3,
    parameter logic [31:0] BootAddr = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_instr_raw_o,
    output logic        out_is_compressed_o,
    output logic        out_illegal_o,
    output logic        out_err_o,
    output logic [31:0] out_pc_o
);
    localparam int unsigned CW = $clog2(HwDepth + 1);

    logic [HwDepth-1:0][15:0] r_hw;
    logic [HwDepth-1:0]       r_err;
    logic [CW-1:0]            r_cnt;
    logic [31:0]              r_pc;
    logic                     r_skip;

    logic [15:0] w_hw0, w_hw1;
    logic        w_is16, w_fire, w_push, w_dec_ill;
    logic [31:0] w_raw, w_dec;
    logic [1:0]  w_pop;
    logic [CW:0] w_space;

    assign w_hw0  = r_hw[0];
    assign w_hw1  = r_hw[1];
    assign w_is16 = RVC && (w_hw0[1:0] != 2'b11);
    assign w_raw  = w_is16 ? {16'h0, w_hw0} : {w_hw1, w_hw0};

    ibex_compressed_decoder u_dec (
        .instr_i         (w_hw0),
        .instr_o         (w_dec),
        .illegal_instr_o (w_dec_ill)
    );

    assign out_instr_o         = w_is16 ? w_dec : w_raw;
    assign out_instr_raw_o     = w_raw;
    assign out_is_compressed_o = w_is16;
    assign out_illegal_o       = w_is16 ? w_dec_ill
                               : (!RVC && (w_hw0[1:0] != 2'b11));
    // A faulting oldest halfword is reported alone; its partner is not trusted.
    assign out_err_o           = r_err[0] || (!w_is16 && r_err[1]);
    assign out_pc_o            = r_pc;

    assign out_valid_o = !flush_i && ((r_cnt >= CW'(2)) ||
                         ((r_cnt == CW'(1)) && (w_is16 || r_err[0])));
    assign w_fire = out_valid_o && out_ready_i;
    assign w_pop  = !w_fire ? 2'd0 : (r_err[0] || w_is16) ? 2'd1 : 2'd2;

    assign w_space    = (CW+1)'(HwDepth) - {1'b0, r_cnt} + (CW+1)'(w_pop);
    assign in_ready_o = !flush_i && (w_space >= (CW+1)'(2));
    assign w_push     = in_valid_i && in_ready_o;

    // Zero-padded view so the shift never indexes past the buffer.
    logic [HwDepth+1:0][15:0] w_ext;
    logic [HwDepth+1:0]       w_ext_err;
    logic [HwDepth-1:0][15:0] w_hw_n;
    logic [HwDepth-1:0]       w_err_n;
    logic [CW-1:0]            w_base, w_cnt_n;

    always_comb begin
        w_ext     = '0;
        w_ext_err = '0;
        w_ext[HwDepth-1:0]     = r_hw;
        w_ext_err[HwDepth-1:0] = r_err;
        w_base  = r_cnt - CW'(w_pop);
        w_hw_n  = '0;
        w_err_n = '0;
        for (int i = 0; i < HwDepth; i++) begin
            unique case (w_pop)
                2'd1: begin
                    w_hw_n[i]  = w_ext[i+1];
                    w_err_n[i] = w_ext_err[i+1];
                end
                2'd2: begin
                    w_hw_n[i]  = w_ext[i+2];
                    w_err_n[i] = w_ext_err[i+2];
                end
                default: begin
                    w_hw_n[i]  = w_ext[i];
                    w_err_n[i] = w_ext_err[i];
                end
            endcase
            if (w_push) begin
                if (r_skip) begin
                    if (CW'(i) == w_base) begin
                        w_hw_n[i]  = in_rdata_i[31:16];
                        w_err_n[i] = in_err_i;
                    end
                end else begin
                    if (CW'(i) == w_base) begin
                        w_hw_n[i]  = in_rdata_i[15:0];
                        w_err_n[i] = in_err_i;
                    end
                    if (CW'(i) == w_base + CW'(1)) begin
                        w_hw_n[i]  = in_rdata_i[31:16];
                        w_err_n[i] = in_err_i;
                    end
                end
            end
        end
        w_cnt_n = w_base;
        if (w_push) begin
            w_cnt_n = w_base + (r_skip ? CW'(1) : CW'(2));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hw   <= '0;
            r_err  <= '0;
            r_cnt  <= '0;
            r_pc   <= BootAddr & ~32'h1;
            r_skip <= 1'b0;
        end else if (flush_i) begin
            r_cnt  <= '0;
            r_pc   <= flush_pc_i & ~32'h1;
            r_skip <= flush_pc_i[1];
        end else begin
            r_hw  <= w_hw_n;
            r_err <= w_err_n;
            r_cnt <= w_cnt_n;
            r_pc  <= r_pc + {29'b0, w_pop, 1'b0};
            if (w_push) begin
                r_skip <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ibex_fetch_align_expand.sv
// Scoreboard bench for ibex_fetch_align_expand.
// Expected instructions are queued at stimulus time, compared on output fire.

module tb_ibex_fetch_align_expand;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        in_valid;
    logic [31:0] in_rdata;
    logic        in_err;
    logic        out_ready;

    logic        in_ready, out_valid, out_c, out_ill, out_err;
    logic [31:0] out_instr, out_raw, out_pc;
    logic        r0_in_ready, r0_valid, r0_c, r0_ill, r0_err;
    logic [31:0] r0_instr, r0_raw, r0_pc;

    always #5 clk = ~clk;

    ibex_fetch_align_expand #(.RVC(1'b1), .HwDepth(3), .BootAddr(32'h1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_pc_i(flush_pc),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_rdata_i(in_rdata),
        .in_err_i(in_err), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_instr_o(out_instr), .out_instr_raw_o(out_raw),
        .out_is_compressed_o(out_c), .out_illegal_o(out_ill),
        .out_err_o(out_err), .out_pc_o(out_pc)
    );

    ibex_fetch_align_expand #(.RVC(1'b0), .HwDepth(3), .BootAddr(32'h0)) u_dut_r0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_pc_i(flush_pc),
        .in_valid_i(in_valid), .in_ready_o(r0_in_ready), .in_rdata_i(in_rdata),
        .in_err_i(in_err), .out_valid_o(r0_valid), .out_ready_i(out_ready),
        .out_instr_o(r0_instr), .out_instr_raw_o(r0_raw),
        .out_is_compressed_o(r0_c), .out_illegal_o(r0_ill),
        .out_err_o(r0_err), .out_pc_o(r0_pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] raw;
        logic [31:0] pc;
        logic        c;
        logic [1:0]  kind;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic exp_ok(input logic [31:0] i, input logic [31:0] r,
                          input logic [31:0] pc, input logic c);
        sb.push_back('{instr: i, raw: r, pc: pc, c: c, kind: 2'd0});
    endtask

    task automatic exp_ill(input logic [31:0] pc, input logic c);
        sb.push_back('{instr: 32'h0, raw: 32'h0, pc: pc, c: c, kind: 2'd1});
    endtask

    task automatic exp_err(input logic [31:0] pc);
        sb.push_back('{instr: 32'h0, raw: 32'h0, pc: pc, c: 1'b0, kind: 2'd2});
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_out", {31'b0, out_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("pc", out_pc, e.pc);
                case (e.kind)
                    2'd0: begin
                        chk("instr", out_instr, e.instr);
                        chk("raw", out_raw, e.raw);
                        chk("is_c", {31'b0, out_c}, {31'b0, e.c});
                        chk("illegal", {31'b0, out_ill}, 32'h0);
                        chk("err", {31'b0, out_err}, 32'h0);
                    end
                    2'd1: begin
                        chk("illegal", {31'b0, out_ill}, 32'h1);
                        chk("is_c", {31'b0, out_c}, {31'b0, e.c});
                    end
                    default: chk("err", {31'b0, out_err}, 32'h1);
                endcase
            end
        end
    end

    task automatic put(input logic [31:0] w, input logic e, output int waited);
        in_valid = 1'b1;
        in_rdata = w;
        in_err   = e;
        waited   = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
        end
        if (!in_ready) chk("put_timeout", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain", sb.size(), 32'h0);
        @(negedge clk);
        chk("idle", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] snap_instr, snap_pc;

    initial begin
        int w;
        rst_n = 1'b0; flush = 1'b0; flush_pc = '0;
        in_valid = 1'b0; in_rdata = '0; in_err = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;

        // aligned 32-bit stream
        for (int i = 0; i < 3; i++) exp_ok(32'h13, 32'h13, 32'(4 * i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            put(32'h0000_0013, 1'b0, w);
            chk("stream_ready", w, 32'h0);
        end
        drain();

        // two compressed in one word
        do_flush(32'h0);
        exp_ok(32'h0015_0513, 32'h0505, 32'h0, 1'b1);
        exp_ok(32'h0010_0513, 32'h4505, 32'h2, 1'b1);
        put(32'h4505_0505, 1'b0, w);
        drain();

        // straddling 32-bit instruction
        do_flush(32'h0);
        exp_ok(32'h0015_0513, 32'h0505, 32'h0, 1'b1);
        exp_ok(32'h0000_0013, 32'h0000_0013, 32'h2, 1'b0);
        exp_ok(32'h0015_0513, 32'h0505, 32'h6, 1'b1);
        put(32'h0013_0505, 1'b0, w);
        put(32'h0505_0000, 1'b0, w);
        drain();

        // flush to a halfword-aligned target
        do_flush(32'h102);
        exp_ok(32'h0015_0513, 32'h0505, 32'h102, 1'b1);
        put(32'h0505_0001, 1'b0, w);
        drain();

        // bus error: each halfword popped alone
        do_flush(32'h0);
        exp_err(32'h0);
        exp_err(32'h2);
        put(32'h0000_0013, 1'b1, w);
        drain();

        // illegal compressed then c.nop
        do_flush(32'h0);
        exp_ill(32'h0, 1'b1);
        exp_ok(32'h0000_0013, 32'h0001, 32'h2, 1'b1);
        put(32'h0001_0000, 1'b0, w);
        drain();

        // RVC=0 instance: non-11 low bits are a 32-bit illegal instruction
        do_flush(32'h0);
        exp_ok(32'h0015_0513, 32'h0505, 32'h0, 1'b1);
        exp_ill(32'h2, 1'b1);
        put(32'h0000_0505, 1'b0, w);
        @(negedge clk);
        chk("r0_valid", {31'b0, r0_valid}, 32'h1);
        chk("r0_illegal", {31'b0, r0_ill}, 32'h1);
        chk("r0_instr", r0_instr, 32'h0000_0505);
        chk("r0_raw", r0_raw, 32'h0000_0505);
        chk("r0_is_c", {31'b0, r0_c}, 32'h0);
        chk("r0_pc", r0_pc, 32'h0);
        @(negedge clk);
        chk("r0_pc_next", r0_pc, 32'h4);
        chk("r0_valid_next", {31'b0, r0_valid}, 32'h0);
        @(posedge clk);
        #1;
        drain();

        // backpressure with a 16/32-bit mix
        do_flush(32'h0);
        exp_ok(32'h0015_0513, 32'h0505, 32'h0, 1'b1);
        exp_ok(32'h0000_0013, 32'h0000_0013, 32'h2, 1'b0);
        exp_ok(32'h0015_0513, 32'h0505, 32'h6, 1'b1);
        exp_ok(32'h0015_0513, 32'h0505, 32'h8, 1'b1);
        exp_ok(32'h0010_0513, 32'h4505, 32'ha, 1'b1);
        out_ready = 1'b0;
        fork
            begin
                int wt;
                put(32'h0013_0505, 1'b0, wt);
                put(32'h0505_0000, 1'b0, wt);
                put(32'h4505_0505, 1'b0, wt);
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                chk("bp_valid", {31'b0, out_valid}, 32'h1);
                snap_instr = out_instr;
                snap_pc    = out_pc;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_instr", out_instr, snap_instr);
                    chk("bp_pc", out_pc, snap_pc);
                    chk("bp_hold", {31'b0, out_valid}, 32'h1);
                end
                chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset in the middle of an instruction
        do_flush(32'h0);
        out_ready = 1'b0;
        put(32'h0000_0013, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'h1);
        chk("mid_rst_pc", out_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'b0, out_valid}, 32'h0);
        chk("post_rst_sb", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
